bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: grants a single RAM port to either the instruction or the data requester.
// Optional macro BUS_ARBITER_FAIR_EN: simultaneous requests alternate instead of data always winning.
module bus_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [1:0]  grant,
  output logic        err
);

  localparam int CW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
  localparam logic [CW-1:0] MaxWait = CW'(MAX_WAIT);
  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT, ERR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lastServed_q, lastServed_d;
  logic          dReq;
  logic          dataWins;
  logic          ownReq;

  assign dReq = dREN | dWEN;

  // lastServed_q is 1 when the data side completed most recently.
`ifdef BUS_ARBITER_FAIR_EN
  assign dataWins = ~iREN | ~lastServed_q;
`else
  assign dataWins = 1'b1;
`endif

  assign ownReq = (state_q == IGNT) ? iREN : dReq;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lastServed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lastServed_q <= lastServed_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lastServed_d = lastServed_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dReq && dataWins) state_d = DGNT;
        else if (iREN)        state_d = IGNT;
      end
      IGNT, DGNT: begin
        // Abort takes precedence so a dropped request never completes or errors.
        if (!ownReq) begin
          state_d = IDLE;
        end else if (ramstate == RamAccess) begin
          state_d      = IDLE;
          lastServed_d = (state_q == DGNT);
        end else if (ramstate == RamError || cnt_q == MaxWait) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    grant    = 2'b00;
    case (state_q)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        grant   = 2'b01;
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        grant    = 2'b10;
      end
      default: ;
    endcase
  end

  assign err   = (state_q == ERR);
  assign iwait = iREN & ~(state_q == IGNT && ramstate == RamAccess);
  assign dwait = dReq & ~(state_q == DGNT && ramstate == RamAccess);
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic, every cycle compared
// against a transaction-level model of who owns the RAM port and for how long.
module tb_bus_arbiter;

  localparam int MaxWait = 15;
  localparam int OwnNone = 0, OwnInstr = 1, OwnData = 2, OwnErr = 3;
  localparam logic [1:0] RsFree = 2'd0, RsBusy = 2'd1, RsAccess = 2'd2, RsError = 2'd3;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;

  // Model: who owns the port, the cycle its ownership began, and who completed last.
  int mOwner = OwnNone;
  int mGrantStart = 0;
  bit mLastData = 1'b0;
  bit mValid = 1'b0;

  bus_arbiter #(.MAX_WAIT(MaxWait)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant(grant), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h cycle=%0d", name, act, exp, cycleNo);
    end
  endtask

  // Expected outputs follow from who owns the port and the current inputs.
  task automatic compareAll();
    logic [1:0]  eGrant;
    logic        eRen, eWen, eIwait, eDwait;
    logic [31:0] eAddr, eStore;
    eGrant = 2'b00; eRen = 1'b0; eWen = 1'b0; eAddr = 32'd0; eStore = 32'd0;
    if (mOwner == OwnInstr) begin
      eGrant = 2'b01; eRen = 1'b1; eAddr = iaddr;
    end else if (mOwner == OwnData) begin
      eGrant = 2'b10; eWen = dWEN; eRen = dREN && !dWEN; eAddr = daddr; eStore = dstore;
    end
    eIwait = iREN && !(mOwner == OwnInstr && ramstate == RsAccess);
    eDwait = (dREN || dWEN) && !(mOwner == OwnData && ramstate == RsAccess);
    checkOutput("grant", {30'd0, grant}, {30'd0, eGrant});
    checkOutput("err", {31'd0, err}, {31'd0, (mOwner == OwnErr)});
    checkOutput("iwait", {31'd0, iwait}, {31'd0, eIwait});
    checkOutput("dwait", {31'd0, dwait}, {31'd0, eDwait});
    checkOutput("iload", iload, ramload);
    checkOutput("dload", dload, ramload);
    checkOutput("ramREN", {31'd0, ramREN}, {31'd0, eRen});
    checkOutput("ramWEN", {31'd0, ramWEN}, {31'd0, eWen});
    checkOutput("ramaddr", ramaddr, eAddr);
    checkOutput("ramstore", ramstore, eStore);
  endtask

  task automatic stepModel();
    bit dReq, ownReq, dataWins;
    dReq = dREN || dWEN;
`ifdef BUS_ARBITER_FAIR_EN
    dataWins = !iREN || !mLastData;
`else
    dataWins = 1'b1;
`endif
    if (!nRST) begin
      mOwner = OwnNone;
      mLastData = 1'b0;
    end else if (mOwner == OwnNone) begin
      if (dReq && dataWins) begin
        mOwner = OwnData; mGrantStart = cycleNo + 1;
      end else if (iREN) begin
        mOwner = OwnInstr; mGrantStart = cycleNo + 1;
      end
    end else if (mOwner == OwnErr) begin
      mOwner = OwnNone;
    end else begin
      ownReq = (mOwner == OwnInstr) ? iREN : dReq;
      if (!ownReq) mOwner = OwnNone;
      else if (ramstate == RsAccess) begin
        mLastData = (mOwner == OwnData);
        mOwner = OwnNone;
      end else if (ramstate == RsError || (cycleNo - mGrantStart) >= MaxWait) begin
        mOwner = OwnErr;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ir, input logic [31:0] ia,
                               input bit dr, input bit dw, input logic [31:0] da,
                               input logic [31:0] ds, input logic [31:0] rl,
                               input logic [1:0] rs);
    @(negedge CLK);
    nRST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    #1;
    if (mValid) compareAll();
  endtask

  task automatic endCycle();
    @(posedge CLK);
    stepModel();
    mValid = 1'b1;
    cycleNo++;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, RsFree);
    endCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, RsFree);
    endCycle();
  endtask

  int errCount;
  int errCycle;
  int dwaitLow;
  bit ir, dr, dw, rst;
  logic [1:0] rs;
  int r;

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = RsFree;
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, RsFree);
    checkOutput("rst_grant", {30'd0, grant}, 32'd0);
    checkOutput("rst_ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("rst_ramaddr", ramaddr, 32'd0);
    endCycle();

    // Minimum-latency instruction fetch
    applyStimulus(1, 1, 32'h40, 0, 0, 0, 0, 0, RsBusy);
    checkOutput("fetch_c0_grant", {30'd0, grant}, 32'd0);
    endCycle();
    applyStimulus(1, 1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, RsAccess);
    checkOutput("fetch_c1_grant", {30'd0, grant}, 32'd1);
    checkOutput("fetch_c1_iwait", {31'd0, iwait}, 32'd0);
    checkOutput("fetch_c1_iload", iload, 32'hDEADBEEF);
    checkOutput("fetch_c1_ramaddr", ramaddr, 32'h40);
    endCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, RsFree);
    checkOutput("fetch_c2_grant", {30'd0, grant}, 32'd0);
    endCycle();

`ifdef BUS_ARBITER_FAIR_EN
    // Both sides request continuously and complete immediately
    doReset();
    applyStimulus(1, 1, 32'h10, 1, 0, 32'h20, 0, 0, RsAccess);
    endCycle();
    for (int k = 0; k < 5; k++) begin
      logic [1:0] want [5];
      want = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      applyStimulus(1, 1, 32'h10, 1, 0, 32'h20, 0, 0, RsAccess);
      checkOutput("fair_seq_grant", {30'd0, grant}, {30'd0, want[k]});
      endCycle();
    end
`else
    // Simultaneous request: data wins, instruction follows after the bubble
    applyStimulus(1, 1, 32'h44, 0, 1, 32'h100, 32'd5, 0, RsBusy);
    endCycle();
    applyStimulus(1, 1, 32'h44, 0, 1, 32'h100, 32'd5, 0, RsAccess);
    checkOutput("prio_grant", {30'd0, grant}, 32'd2);
    checkOutput("prio_ramWEN", {31'd0, ramWEN}, 32'd1);
    checkOutput("prio_ramstore", ramstore, 32'd5);
    checkOutput("prio_ramaddr", ramaddr, 32'h100);
    endCycle();
    applyStimulus(1, 1, 32'h44, 0, 0, 0, 0, 0, RsFree);
    checkOutput("prio_bubble", {30'd0, grant}, 32'd0);
    endCycle();
    applyStimulus(1, 1, 32'h44, 0, 0, 0, 0, 0, RsAccess);
    checkOutput("prio_igrant", {30'd0, grant}, 32'd1);
    endCycle();
`endif

    // Timeout: BUSY forever on a data read
    doReset();
    applyStimulus(1, 0, 0, 1, 0, 32'h200, 0, 0, RsBusy);
    endCycle();
    errCount = 0; errCycle = -1; dwaitLow = 0;
    for (int k = 1; k <= 19; k++) begin
      applyStimulus(1, 0, 0, 1, 0, 32'h200, 0, 0, RsBusy);
      if (k == 1) checkOutput("tmo_grant", {30'd0, grant}, 32'd2);
      if (err) begin errCount++; errCycle = k; end
      if (!dwait) dwaitLow++;
      if (k == 19) checkOutput("tmo_regrant", {30'd0, grant}, 32'd2);
      endCycle();
    end
    checkOutput("tmo_err_count", errCount, 32'd1);
    checkOutput("tmo_err_offset", errCycle - 1, 32'd16);
    checkOutput("tmo_dwait_low", dwaitLow, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, RsFree);
    endCycle();

    // RAM ERROR during an instruction grant
    applyStimulus(1, 1, 32'h80, 0, 0, 0, 0, 0, RsBusy);
    endCycle();
    applyStimulus(1, 1, 32'h80, 0, 0, 0, 0, 0, RsError);
    checkOutput("rerr_grant", {30'd0, grant}, 32'd1);
    endCycle();
    applyStimulus(1, 1, 32'h80, 0, 0, 0, 0, 0, RsFree);
    checkOutput("rerr_err", {31'd0, err}, 32'd1);
    checkOutput("rerr_iwait", {31'd0, iwait}, 32'd1);
    endCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, RsFree);
    checkOutput("rerr_err_gone", {31'd0, err}, 32'd0);
    checkOutput("rerr_idle", {30'd0, grant}, 32'd0);
    endCycle();

    // Reset in the middle of a data grant
    applyStimulus(1, 0, 0, 1, 0, 32'h300, 0, 0, RsBusy);
    endCycle();
    applyStimulus(0, 0, 0, 1, 0, 32'h300, 0, 0, RsBusy);
    checkOutput("mrst_ramREN_before", {31'd0, ramREN}, 32'd1);
    endCycle();
    applyStimulus(1, 0, 0, 1, 0, 32'h300, 0, 0, RsBusy);
    checkOutput("mrst_grant", {30'd0, grant}, 32'd0);
    checkOutput("mrst_ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("mrst_ramaddr", ramaddr, 32'd0);
    endCycle();

    // Randomized traffic with sticky requests and long BUSY stretches
    ir = 0; dr = 0; dw = 0;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) != 0);
      ir = ir ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 3);
      if (dr || dw) begin
        if ($urandom_range(0, 9) == 0) begin dr = 0; dw = 0; end
      end else if ($urandom_range(0, 9) < 3) begin
        dr = $urandom_range(0, 1); dw = $urandom_range(0, 1);
      end
      if (((k / 150) % 4) == 3) begin
        rs = ($urandom_range(0, 49) == 0) ? RsError : RsBusy;
      end else begin
        r = $urandom_range(0, 19);
        rs = (r < 7) ? RsAccess : (r < 17) ? RsBusy : (r < 19) ? RsFree : RsError;
      end
      applyStimulus(rst, ir, $urandom, dr, dw, $urandom, $urandom, $urandom, rs);
      endCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
